// File: rtl/rv_instr_encoder.sv
// rv_instr_encoder: packs decoded RV32I field bundles into R/I/S/B/J words,
// buffers them in a DEPTH-entry FIFO and streams them to consecutive
// instruction-memory addresses starting at BASE_ADDR.
// Optional build macro: RV_ENC_IMM_CHECK_EN (range-check immediates at accept).
module rv_instr_encoder #(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_cls,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic              in_funct7b5,
    input  logic [20:0]       in_imm,
    output logic              mem_we,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              err,
    output logic [15:0]       words
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

    typedef enum logic [2:0] {
        CLS_R      = 3'd0,
        CLS_I      = 3'd1,
        CLS_LOAD   = 3'd2,
        CLS_STORE  = 3'd3,
        CLS_BRANCH = 3'd4,
        CLS_JAL    = 3'd5
    } cls_e;

    logic [31:0]       r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [PTR_W:0]    r_count;
    logic [ADDR_W-1:0] r_addr;
    logic [15:0]       r_words;
    logic              r_err;

    cls_e        w_cls;
    logic        w_full;
    logic        w_busy;
    logic        w_accept;
    logic        w_pop;
    logic        w_push;
    logic        w_legal;
    logic        w_shift;
    logic        w_imm_ok;
    logic [31:0] w_word;

    assign w_cls    = cls_e'(in_cls);
    assign w_full   = (r_count == (PTR_W + 1)'(DEPTH));
    assign w_busy   = (r_count != '0);
    assign in_ready = !w_full && !clear;
    assign w_accept = in_valid && in_ready;
    assign w_pop    = w_busy && mem_ready && !clear;
    assign w_legal  = (in_cls <= 3'd5);
    assign w_shift  = (w_cls == CLS_I) && (in_funct3[1:0] == 2'b01);
    assign w_push   = w_accept && w_legal && w_imm_ok;

    // Field packing into the 32-bit instruction word for the offered class
    always_comb begin
        w_word = '0;
        case (w_cls)
            CLS_R:      w_word = {1'b0, in_funct7b5, 5'b0, in_rs2, in_rs1, in_funct3, in_rd, 7'b0110011};
            CLS_I: begin
                w_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b0010011};
                if (w_shift) w_word[31:20] = {1'b0, in_funct7b5, 5'b0, in_imm[4:0]};
            end
            CLS_LOAD:   w_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b0000011};
            CLS_STORE:  w_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], 7'b0100011};
            CLS_BRANCH: w_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                                  in_imm[4:1], in_imm[11], 7'b1100011};
            CLS_JAL:    w_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, 7'b1101111};
            default:    w_word = '0;
        endcase
    end

`ifdef RV_ENC_IMM_CHECK_EN
    // Immediate range check: sign-extension bits must agree, offsets must be even
    always_comb begin
        w_imm_ok = 1'b1;
        case (w_cls)
            CLS_I: begin
                if (w_shift) w_imm_ok = (in_imm[20:5] == '0);
                else         w_imm_ok = (in_imm[20:11] == '0) || (&in_imm[20:11]);
            end
            CLS_LOAD, CLS_STORE: w_imm_ok = (in_imm[20:11] == '0) || (&in_imm[20:11]);
            CLS_BRANCH: w_imm_ok = ((in_imm[20:12] == '0) || (&in_imm[20:12])) && !in_imm[0];
            CLS_JAL:    w_imm_ok = !in_imm[0];
            default:    w_imm_ok = 1'b1;
        endcase
    end
`else
    logic w_unused_imm0;
    assign w_unused_imm0 = in_imm[0];
    assign w_imm_ok      = 1'b1;
`endif

    // FIFO storage and pointers; clear empties the queue but leaves storage as is
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (clear) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= w_word;
                r_wptr        <= r_wptr + 1'b1;
            end
            if (w_pop) r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Write address, saturating word count and sticky error flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr  <= BASE;
            r_words <= '0;
            r_err   <= 1'b0;
        end else if (clear) begin
            r_addr  <= BASE;
            r_words <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_pop) begin
                r_addr <= r_addr + ADDR_W'(4);
                if (r_words != '1) r_words <= r_words + 16'd1;
            end
            if (w_accept && !(w_legal && w_imm_ok)) r_err <= 1'b1;
        end
    end

    assign busy      = w_busy;
    assign mem_we    = w_busy;
    assign mem_wdata = r_mem[r_rptr];
    assign mem_addr  = r_addr;
    assign err       = r_err;
    assign words     = r_words;
endmodule

// File: tb/tb_rv_instr_encoder.sv
// Testbench for rv_instr_encoder: directed test-plan steps followed by random
// traffic, checked against a queue-based reference model.
module tb_rv_instr_encoder;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned ADDR_W = 10;
    localparam int unsigned BASE   = 'h3F0;
    localparam int unsigned AMOD   = 1 << ADDR_W;
    localparam int unsigned WMOD   = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, clear, in_valid, mem_ready, in_funct7b5;
    logic [2:0]  in_cls, in_funct3;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [20:0] in_imm;

    logic        in_ready, mem_we, busy, err;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [15:0] words;

    logic        w_in_ready, w_mem_we, w_busy, w_err;
    logic [3:0]  w_mem_addr;
    logic [31:0] w_mem_wdata;
    logic [15:0] w_words;

    rv_instr_encoder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
        .in_cls(in_cls), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_funct3(in_funct3), .in_funct7b5(in_funct7b5), .in_imm(in_imm),
        .mem_we(mem_we), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .busy(busy), .err(err), .words(words)
    );

    rv_instr_encoder #(.DEPTH(DEPTH), .ADDR_W(4), .BASE_ADDR(0)) dut_w (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(w_in_ready),
        .in_cls(in_cls), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_funct3(in_funct3), .in_funct7b5(in_funct7b5), .in_imm(in_imm),
        .mem_we(w_mem_we), .mem_ready(mem_ready), .mem_addr(w_mem_addr), .mem_wdata(w_mem_wdata),
        .busy(w_busy), .err(w_err), .words(w_words)
    );

    int unsigned errors = 0;
    int unsigned checks = 0;

    logic [31:0] q[$];
    int unsigned m_addr, m_waddr, m_words;
    bit          m_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_enc(input int unsigned cls, input int unsigned rd,
                                            input int unsigned rs1, input int unsigned rs2,
                                            input int unsigned f3, input int unsigned f7,
                                            input int unsigned imm);
        int unsigned regs;
        regs = (f3 << 12) + (rs1 << 15);
        case (cls)
            0: return 32'h33 + (rd << 7) + regs + (rs2 << 20) + (f7 << 30);
            1: begin
                if (f3 == 1 || f3 == 5) return 32'h13 + (rd << 7) + regs + ((imm % 32) << 20) + (f7 << 30);
                return 32'h13 + (rd << 7) + regs + ((imm % 4096) << 20);
            end
            2: return 32'h03 + (rd << 7) + regs + ((imm % 4096) << 20);
            3: return 32'h23 + ((imm % 32) << 7) + regs + (rs2 << 20) + (((imm / 32) % 128) << 25);
            4: return 32'h63 + (((imm / 2048) % 2) << 7) + (((imm / 2) % 16) << 8) + regs
                      + (rs2 << 20) + (((imm / 32) % 64) << 25) + (((imm / 4096) % 2) << 31);
            5: return 32'h6F + (rd << 7) + (((imm / 4096) % 256) << 12) + (((imm / 2048) % 2) << 20)
                      + (((imm / 2) % 1024) << 21) + (((imm / 1048576) % 2) << 31);
            default: return 32'h0;
        endcase
    endfunction

    function automatic bit imm_ok(input int unsigned cls, input int unsigned f3, input int unsigned imm);
`ifdef RV_ENC_IMM_CHECK_EN
        int s;
        s = (imm >= 'h100000) ? int'(imm) - 'h200000 : int'(imm);
        case (cls)
            1: begin
                if (f3 == 1 || f3 == 5) return imm < 32;
                return s >= -2048 && s <= 2047;
            end
            2, 3: return s >= -2048 && s <= 2047;
            4: return s >= -4096 && s <= 4095 && (imm % 2) == 0;
            5: return (imm % 2) == 0;
            default: return 1'b1;
        endcase
`else
        return (cls + f3 + imm) >= 0;
`endif
    endfunction

    task automatic drive(input logic v, input logic [2:0] cls, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                         input logic f7, input logic [20:0] imm);
        in_valid = v; in_cls = cls; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
        in_funct3 = f3; in_funct7b5 = f7; in_imm = imm;
    endtask

    task automatic model_reset();
        q.delete();
        m_addr = BASE; m_waddr = 0; m_words = 0; m_err = 1'b0;
    endtask

    // One clock: check outputs against the model, advance the model, step the clock
    task automatic tick();
        bit exp_ready, exp_we;
        #1;
        exp_ready = (q.size() < DEPTH) && !clear;
        exp_we    = (q.size() != 0);
        chk("in_ready", 32'(in_ready), 32'(exp_ready));
        chk("mem_we", 32'(mem_we), 32'(exp_we));
        chk("busy", 32'(busy), 32'(exp_we));
        chk("err", 32'(err), 32'(m_err));
        chk("words", 32'(words), m_words);
        chk("mem_addr", 32'(mem_addr), m_addr);
        chk("w_in_ready", 32'(w_in_ready), 32'(exp_ready));
        chk("w_mem_we", 32'(w_mem_we), 32'(exp_we));
        chk("w_busy", 32'(w_busy), 32'(exp_we));
        chk("w_err", 32'(w_err), 32'(m_err));
        chk("w_words", 32'(w_words), m_words);
        chk("w_mem_addr", 32'(w_mem_addr), m_waddr);
        if (exp_we) begin
            chk("mem_wdata", mem_wdata, q[0]);
            chk("w_mem_wdata", w_mem_wdata, q[0]);
        end
        if (clear) begin
            model_reset();
        end else begin
            if (exp_we && mem_ready) begin
                void'(q.pop_front());
                m_addr  = (m_addr + 4) % AMOD;
                m_waddr = (m_waddr + 4) % WMOD;
                if (m_words < 65535) m_words++;
            end
            if (in_valid && exp_ready) begin
                if (in_cls <= 3'd5 && imm_ok(32'(in_cls), 32'(in_funct3), 32'(in_imm)))
                    q.push_back(ref_enc(32'(in_cls), 32'(in_rd), 32'(in_rs1), 32'(in_rs2),
                                        32'(in_funct3), 32'(in_funct7b5), 32'(in_imm)));
                else
                    m_err = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    int unsigned exp_w[5];

    initial begin
        rst_n = 1'b0; clear = 1'b0; mem_ready = 1'b0;
        drive(1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 21'd0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        // Reset values
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), BASE);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_words", 32'(words), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // R-type add then sub
        mem_ready = 1'b1;
        drive(1'b1, 3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 1'b0, 21'd0);
        tick();
        in_valid = 1'b0;
        chk("radd_wdata", mem_wdata, 32'h002081B3);
        chk("radd_addr", 32'(mem_addr), BASE);
        tick();
        drive(1'b1, 3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 1'b1, 21'd0);
        tick();
        in_valid = 1'b0;
        chk("rsub_wdata", mem_wdata, 32'h402081B3);
        chk("rsub_addr", 32'(mem_addr), BASE + 4);
        tick();

        // lw x6,-4(x9) and beq x0,x0,-8
        drive(1'b1, 3'd2, 5'd6, 5'd9, 5'd0, 3'd2, 1'b0, 21'h1FFFFC);
        tick();
        in_valid = 1'b0;
        chk("lw_wdata", mem_wdata, 32'hFFC4A303);
        tick();
        drive(1'b1, 3'd4, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 21'h1FFFF8);
        tick();
        in_valid = 1'b0;
        chk("beq_wdata", mem_wdata, 32'hFE000CE3);
        tick();

        // Backpressure: five bundles into a four-entry FIFO
        clear = 1'b1; tick(); clear = 1'b0;
        mem_ready = 1'b0;
        for (int unsigned i = 0; i < 5; i++) begin
            drive(1'b1, 3'd0, 5'(i + 1), 5'd1, 5'd2, 3'd0, 1'b0, 21'd0);
            if (i == 4) chk("bp_full_ready", 32'(in_ready), 32'd0);
            tick();
        end
        mem_ready = 1'b1;
        tick();
        tick();
        in_valid = 1'b0;
        repeat (6) tick();
        chk("bp_words", 32'(words), 32'd5);

        // Illegal class, then clear with a bundle offered in the clear cycle
        drive(1'b1, 3'd7, 5'd1, 5'd1, 5'd1, 3'd0, 1'b0, 21'd0);
        tick();
        in_valid = 1'b0;
        chk("ill_err", 32'(err), 32'd1);
        chk("ill_busy", 32'(busy), 32'd0);
        tick();
        clear = 1'b1;
        drive(1'b1, 3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 1'b0, 21'd0);
        tick();
        clear = 1'b0; in_valid = 1'b0;
        chk("clr_err", 32'(err), 32'd0);
        chk("clr_words", 32'(words), 32'd0);
        chk("clr_addr", 32'(mem_addr), BASE);
        chk("clr_busy", 32'(busy), 32'd0);
        tick();

        // Address wrap on the ADDR_W=4 instance
        exp_w = '{0, 4, 8, 12, 0};
        for (int unsigned i = 0; i < 6; i++) begin
            if (i < 5) drive(1'b1, 3'd1, 5'(i), 5'd0, 5'd0, 3'd0, 1'b0, 21'(i));
            else in_valid = 1'b0;
            if (i > 0) chk("wrap_addr", 32'(w_mem_addr), exp_w[i - 1]);
            tick();
        end

        // addi with out-of-range immediate
        drive(1'b1, 3'd1, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 21'd4096);
        tick();
        in_valid = 1'b0;
`ifdef RV_ENC_IMM_CHECK_EN
        chk("addi4096_err", 32'(err), 32'd1);
        chk("addi4096_busy", 32'(busy), 32'd0);
`else
        chk("addi4096_wdata", mem_wdata, 32'h00000013);
        chk("addi4096_err", 32'(err), 32'd0);
`endif
        repeat (2) tick();

        // Asynchronous reset mid-transfer discards FIFO content
        mem_ready = 1'b0;
        for (int unsigned i = 0; i < 3; i++) begin
            drive(1'b1, 3'd5, 5'(i), 5'd0, 5'd0, 3'd0, 1'b0, 21'(8 * i));
            tick();
        end
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_mem_we", 32'(mem_we), 32'd0);
        chk("arst_addr", 32'(mem_addr), BASE);
        chk("arst_words", 32'(words), 32'd0);
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        // Random traffic
        for (int unsigned n = 0; n < 400; n++) begin
            clear     = ($urandom_range(0, 24) == 0);
            mem_ready = ($urandom_range(0, 3) != 0);
            drive(($urandom_range(0, 2) != 0), 3'($urandom_range(0, 7)), 5'($urandom),
                  5'($urandom), 5'($urandom), 3'($urandom_range(0, 7)), 1'($urandom),
                  ($urandom_range(0, 1) != 0) ? 21'($urandom) : 21'($urandom_range(0, 63)) - 21'd32);
            if (in_cls == 3'd2 && in_funct3[0]) in_funct3[0] = 1'b0;
            tick();
        end
        clear = 1'b0; in_valid = 1'b0; mem_ready = 1'b1;
        repeat (6) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
